// File: rtl/data_mem_ctrl_if.sv
// Request/response bus of the MEM-stage data memory controller.
// master drives requests; slave accepts them and returns a 1-cycle response.
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// RV32I data memory: byte/half/word loads and stores, 1-cycle response, error flags.
// Ports: CLK, RST (async active-low), bus (slave modport), init_done (sweep finished).
module data_mem_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 512,
  parameter int INIT_MODE = 0
) (
  input  logic              CLK,
  input  logic              RST,
  data_mem_ctrl_if.slave    bus,
  output logic              init_done
);

  localparam int CW = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
  localparam logic [ADDR_W-3:0] DEPTH_I = (ADDR_W-2)'(DEPTH);

  typedef enum logic {
    S_INIT,
    S_IDLE
  } state_t;

  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic init_we;
  logic [31:0] init_val;

  logic [31:0] mem [DEPTH];

  logic ready;
  logic accept;
  logic [ADDR_W-3:0] widx_full;
  logic [CW-1:0] widx;
  logic [1:0] lane;
  logic [2:0] f3;
  logic is_b, is_h, is_w;
  logic bad_f3, misal, oor, err;
  logic [31:0] rword;
  logic [7:0] bsel;
  logic [15:0] hsel;
  logic [31:0] ld;
  logic [3:0] be;
  logic [31:0] wd;
  logic st_we;

  logic rsp_valid_q;
  logic rsp_err_q;
  logic [31:0] rsp_rdata_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= S_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    init_we  = 1'b0;
    unique case (state)
      S_INIT: begin
        init_we = 1'b1;
        cnt_nx  = cnt + 1'b1;
        if (cnt == LAST) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end
      end
      S_IDLE: ;
      default: state_nx = S_INIT;
    endcase
  end

  assign init_val  = (INIT_MODE == 1) ? 32'(cnt) : 32'd0;
  assign ready     = (state == S_IDLE);
  assign init_done = ready;
  assign accept    = bus.req_valid & ready;

  assign widx_full = bus.req_addr[ADDR_W-1:2];
  assign widx      = widx_full[CW-1:0];
  assign lane      = bus.req_addr[1:0];
  assign f3        = bus.req_funct3;

  assign is_b = (f3[1:0] == 2'b00);
  assign is_h = (f3[1:0] == 2'b01);
  assign is_w = (f3[1:0] == 2'b10);

  // Stores only know 000/001/010; loads add the unsigned 100/101.
  assign bad_f3 = bus.req_we
                ? (f3[2] | (f3[1:0] == 2'b11))
                : ((f3[1:0] == 2'b11) | (f3 == 3'b110));
  assign misal  = (is_h & lane[0]) | (is_w & (lane != 2'b00));
  assign oor    = (widx_full >= DEPTH_I);
  assign err    = bad_f3 | misal | oor;

  assign rword = mem[widx];
  assign bsel  = rword[{lane, 3'b000} +: 8];
  assign hsel  = lane[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    ld = 32'd0;
    be = 4'b0000;
    wd = 32'd0;
    unique case (1'b1)
      is_w: begin
        ld = rword;
        be = 4'b1111;
        wd = bus.req_wdata;
      end
      is_h: begin
        ld = {{16{~f3[2] & hsel[15]}}, hsel};
        be = lane[1] ? 4'b1100 : 4'b0011;
        wd = {2{bus.req_wdata[15:0]}};
      end
      is_b: begin
        ld = {{24{~f3[2] & bsel[7]}}, bsel};
        be = 4'b0001 << lane;
        wd = {4{bus.req_wdata[7:0]}};
      end
      default: ;
    endcase
  end

  assign st_we = accept & bus.req_we & ~err;

  // Single write port: the init sweep owns it in INIT, stores in IDLE.
  always_ff @(posedge CLK) begin
    if (init_we) begin
      mem[cnt] <= init_val;
    end else if (st_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      rsp_valid_q <= accept;
      if (accept) begin
        rsp_err_q   <= err;
        rsp_rdata_q <= (err | bus.req_we) ? 32'd0 : ld;
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule
